// File: rtl/synch_fifo_16x8bit.sv
// Single-clock FIFO, DEPTH x DATA_SIZE, with registered read data.
// Flags decode from the occupancy register only, so no input reaches an output combinationally.
module synch_fifo_16x8bit #(
  parameter int DATA_SIZE = 8,
  parameter int DEPTH     = 16
) (
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic [DATA_SIZE-1:0] data_out
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;
  logic                 wr_ok;
  logic                 rd_ok;

  // Handshake: a write is taken when wr_en=1 and fifo_full=0 at the rising edge,
  // a read when rd_en=1 and fifo_empty=0; otherwise the request is silently dropped.
  assign fifo_full  = (count == (AW+1)'(DEPTH));
  assign fifo_empty = (count == '0);
  assign wr_ok      = wr_en && !fifo_full;
  assign rd_ok      = rd_en && !fifo_empty;

  // Storage is not reset; stale words are unreachable because count clears.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + AW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_synch_fifo_16x8bit.sv
// Directed bench for synch_fifo_16x8bit: a reference count plus an expected-data queue
// predict flags and data_out each cycle.
module tb_synch_fifo_16x8bit;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] data_in = '0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] data_out;

  int         checks = 0;
  int         passed = 0;
  int         fails  = 0;
  int         m_count = 0;
  logic [7:0] m_dout = '0;
  logic [7:0] exp_q[$];

  synch_fifo_16x8bit dut (
    .data_in   (data_in),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .clk       (clk),
    .reset_n   (reset_n),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_full"},  8'(fifo_full),  8'(m_count == 16));
    check({tag, "_empty"}, 8'(fifo_empty), 8'(m_count == 0));
    check({tag, "_dout"},  data_out,       m_dout);
  endtask

  // One clock: drive at the falling edge, predict, compare at the next falling edge.
  task automatic cycle(input string tag, input logic w, input logic r, input logic [7:0] d);
    logic w_ok;
    logic r_ok;
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    w_ok = w && (m_count != 16);
    r_ok = r && (m_count != 0);
    @(posedge clk);
    if (r_ok) m_dout = exp_q.pop_front();
    if (w_ok) exp_q.push_back(d);
    if (w_ok && !r_ok) m_count++;
    if (r_ok && !w_ok) m_count--;
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic apply_reset(input int n);
    reset_n = 1'b1;
    repeat (n) begin
      wr_en   = 1'($urandom_range(0, 1));
      rd_en   = 1'($urandom_range(0, 1));
      data_in = 8'($urandom_range(0, 255));
      @(posedge clk);
      @(negedge clk);
      check("rst_empty", 8'(fifo_empty), 8'd1);
      check("rst_full",  8'(fifo_full),  8'd0);
      check("rst_dout",  data_out,       8'h00);
    end
    m_count = 0;
    m_dout  = '0;
    exp_q.delete();
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    reset_n = 1'b0;
  endtask

  initial begin
    apply_reset(3);

    // Fill 0x01..0x10, then an overflow write of 0xAA.
    for (int i = 1; i <= 16; i++) begin
      cycle("fill", 1'b1, 1'b0, 8'(i));
      if (i == 1)  check("fill_not_empty", 8'(fifo_empty), 8'd0);
      if (i == 15) check("fill_not_full_15", 8'(fifo_full), 8'd0);
    end
    check("fill_full_16", 8'(fifo_full), 8'd1);
    cycle("overflow", 1'b1, 1'b0, 8'hAA);
    check("overflow_full", 8'(fifo_full), 8'd1);

    // Drain in order, then an underflow read.
    for (int i = 1; i <= 16; i++) begin
      cycle("drain", 1'b0, 1'b1, 8'h00);
      check("drain_order", data_out, 8'(i));
    end
    check("drain_empty", 8'(fifo_empty), 8'd1);
    cycle("underflow", 1'b0, 1'b1, 8'h00);
    check("underflow_hold", data_out, 8'h10);

    // Wrap-around of both pointers.
    for (int i = 0; i < 10; i++) cycle("wrap_w10", 1'b1, 1'b0, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 10; i++) cycle("wrap_r10", 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 16; i++) cycle("wrap_fill", 1'b1, 1'b0, 8'(8'h20 + i));
    check("wrap_full", 8'(fifo_full), 8'd1);
    for (int i = 0; i < 16; i++) begin
      cycle("wrap_drain", 1'b0, 1'b1, 8'h00);
      check("wrap_order", data_out, 8'(8'h20 + i));
    end

    // Simultaneous access at occupancy 5.
    for (int i = 0; i < 5; i++) cycle("sim_pre", 1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 20; i++) begin
      cycle("sim_both", 1'b1, 1'b1, 8'(8'h45 + i));
      check("sim_order", data_out, 8'(8'h40 + i));
    end
    for (int i = 0; i < 5; i++) cycle("sim_drain", 1'b0, 1'b1, 8'h00);
    check("sim_drained_empty", 8'(fifo_empty), 8'd1);
    cycle("both_empty", 1'b1, 1'b1, 8'h77);
    check("both_empty_not_empty", 8'(fifo_empty), 8'd0);
    check("both_empty_dout_hold", data_out, 8'h58);
    for (int i = 0; i < 15; i++) cycle("sim_refill", 1'b1, 1'b0, 8'(8'h80 + i));
    check("sim_refill_full", 8'(fifo_full), 8'd1);
    cycle("both_full", 1'b1, 1'b1, 8'hEE);
    check("both_full_not_full", 8'(fifo_full), 8'd0);
    check("both_full_read", data_out, 8'h77);
    for (int i = 0; i < 15; i++) cycle("sim_flush", 1'b0, 1'b1, 8'h00);
    check("sim_flush_last", data_out, 8'h8E);

    // Mid-operation reset, asserted between edges.
    for (int i = 0; i < 8; i++) cycle("mid_store", 1'b1, 1'b0, 8'(8'hC1 + i));
    cycle("mid_read", 1'b0, 1'b1, 8'h00);
    #2 reset_n = 1'b1;
    #1;
    check("async_empty", 8'(fifo_empty), 8'd1);
    check("async_full",  8'(fifo_full),  8'd0);
    check("async_dout",  data_out,       8'h00);
    @(negedge clk);
    m_count = 0;
    m_dout  = '0;
    exp_q.delete();
    reset_n = 1'b0;
    check_outputs("post_rst");
    cycle("post_rst_w", 1'b1, 1'b0, 8'h55);
    cycle("post_rst_r", 1'b0, 1'b1, 8'h00);
    check("post_rst_data", data_out, 8'h55);
    check("post_rst_empty", 8'(fifo_empty), 8'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
